// File: rtl/game_ctrl.sv
// Game sequencer: debounced start/move button, IDLE/PLAY/DEAD/DONE flow,
// timed game-over freeze and best-score register.
module game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DEAD_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       collision,
    input  logic [6:0] score,
    output logic       move_btn,
    output logic       play_reset,
    output logic [1:0] state,
    output logic       game_over,
    output logic [6:0] high_score
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DEAD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] DEAD_LAST = 26'(DEAD_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_btn_db;
    logic        r_btn_db_q;
    logic [1:0]  r_arm_dly;
    logic        r_armed;
    logic [19:0] r_db_cnt;
    logic [25:0] r_dead_cnt;
    logic [6:0]  r_high_score;
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_press;
    logic        w_dead_end;
    logic        w_die;

    // Presses are only honoured once the button has been seen released after
    // reset, so a button held through rst_n release never starts a game.
    assign w_press    = r_btn_db & ~r_btn_db_q & r_armed;
    assign w_dead_end = (r_dead_cnt == DEAD_LAST);
    assign w_die      = (r_state == S_PLAY) & collision;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
            r_arm_dly  <= '0;
            r_armed    <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_btn_db_q <= r_btn_db;
            r_arm_dly  <= {r_arm_dly[0], 1'b1};
            if (r_arm_dly[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            if (r_sync2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dead_cnt <= '0;
        end else if (w_die) begin
            r_dead_cnt <= '0;
        end else if (r_state == S_DEAD) begin
            r_dead_cnt <= w_dead_end ? '0 : r_dead_cnt + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_score <= '0;
        end else if (w_die && (score > r_high_score)) begin
            r_high_score <= score;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        play_reset  = 1'b0;
        move_btn    = 1'b0;
        case (r_state)
            S_IDLE: begin
                play_reset = 1'b1;
                if (w_press) w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                move_btn = r_btn_db;
                if (collision) w_state_nxt = S_DEAD;
            end
            S_DEAD: begin
                if (w_dead_end) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_press) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign state      = r_state;
    assign game_over  = r_state[1];
    assign high_score = r_high_score;

endmodule
